// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller.
//   - Forwarding select encodings driven on fwd_a / fwd_b.
//   - Default register-address width and MDU occupancy.
//   - fwd_pick: turns per-operand EXE/MEM match flags into a select.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned DEFAULT_AW         = 5;
  localparam int unsigned DEFAULT_MDU_CYCLES = 32;

  typedef enum logic [1:0] {
    FWD_REGFILE  = 2'b00,
    FWD_EXE      = 2'b01,
    FWD_MEM_ALU  = 2'b10,
    FWD_MEM_LOAD = 2'b11
  } fwd_sel_e;

  // The younger producer (EXE) always wins over the older one (MEM).
  function automatic fwd_sel_e fwd_pick(input logic exe_hit, input logic mem_hit,
                                        input logic mem_load);
    fwd_sel_e sel;
    sel = FWD_REGFILE;
    if (exe_hit) begin
      sel = FWD_EXE;
    end else if (mem_hit) begin
      sel = mem_load ? FWD_MEM_LOAD : FWD_MEM_ALU;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mdu_occupancy_ctr.sv
// Occupancy countdown for the multi-cycle multiply/divide unit.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   issue    : an MDU instruction leaves ID this cycle; reload the countdown
//   busy     : countdown is non-zero
module mdu_occupancy_ctr #(
  parameter int unsigned MDU_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic busy
);

  localparam int unsigned CW = $clog2(MDU_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Keeps counting down through memory waits and debug holds: the MDU runs
  // independently of the pipeline registers.
  always_comb begin
    cnt_d = cnt_q;
    if (issue) begin
      cnt_d = CW'(MDU_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, forwarding and stage-control unit for the 5-stage MIPS pipeline.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   debug_en, debug_step        : debug hold and single-step (step is edge-detected)
//   id_*                        : decoded attributes of the instruction in ID
//   exe_*, mem_*                : destination info of instructions in EXE / MEM
//   mem_ready                   : data memory finished the MEM-stage access
//   fwd_a, fwd_b                : operand forwarding selects (see fwd_sel_e)
//   fwd_m                       : store data taken from the load result in WB
//   *_en, *_rst                 : pipeline register enables and synchronous clears
//   mdu_busy                    : MDU still occupied
//   stall_cycles                : saturating count of cycles with ID held
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned AW         = DEFAULT_AW,
  parameter int unsigned MDU_CYCLES = DEFAULT_MDU_CYCLES,
  parameter int unsigned DELAY_SLOT = 1,
  parameter int unsigned SCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug_en,
  input  logic              debug_step,
  input  logic [AW-1:0]     id_rs_addr,
  input  logic [AW-1:0]     id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              id_is_store,
  input  logic              id_is_mdu,
  input  logic              id_reads_hilo,
  input  logic              id_branch_taken,
  input  logic              exe_wen,
  input  logic              exe_is_load,
  input  logic [AW-1:0]     exe_waddr,
  input  logic              mem_wen,
  input  logic              mem_is_load,
  input  logic [AW-1:0]     mem_waddr,
  input  logic              mem_ready,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              fwd_m,
  output logic              if_en,
  output logic              id_en,
  output logic              exe_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic              if_rst,
  output logic              id_rst,
  output logic              exe_rst,
  output logic              mem_rst,
  output logic              wb_rst,
  output logic              mdu_busy,
  output logic [SCNT_W-1:0] stall_cycles
);

  // Operand matches; register 0 is hard-wired and never forwarded.
  logic rs_nz, rt_nz;
  logic rs_exe_hit, rs_mem_hit, rt_exe_hit, rt_mem_hit;
  logic rs_load_hit, rt_load_hit;

  assign rs_nz      = (id_rs_addr != '0);
  assign rt_nz      = (id_rt_addr != '0);
  assign rs_exe_hit = rs_nz & exe_wen & (exe_waddr == id_rs_addr);
  assign rt_exe_hit = rt_nz & exe_wen & (exe_waddr == id_rt_addr);
  assign rs_mem_hit = rs_nz & mem_wen & (mem_waddr == id_rs_addr);
  assign rt_mem_hit = rt_nz & mem_wen & (mem_waddr == id_rt_addr);
  assign rs_load_hit = exe_is_load & rs_exe_hit;
  assign rt_load_hit = exe_is_load & rt_exe_hit;

  // Hazard conditions
  logic load_stall, mdu_stall, mem_wait, dbg_hold, bubble;
  logic step_prev_q;

  // A store only needs rt at MEM, so a load feeding rt is bridged by fwd_m.
  assign load_stall = (id_rs_used & rs_load_hit) |
                      (id_rt_used & rt_load_hit & ~id_is_store);
  assign mdu_stall  = mdu_busy & (id_is_mdu | id_reads_hilo);
  assign mem_wait   = (mem_is_load | mem_wen) & ~mem_ready;
  assign dbg_hold   = debug_en & ~(debug_step & ~step_prev_q);
  assign bubble     = load_stall | mdu_stall;

  // Forwarding selects
  always_comb begin
    fwd_a = FWD_REGFILE;
    fwd_b = FWD_REGFILE;
    fwd_m = 1'b0;
    if (!rst) begin
      fwd_a = fwd_pick(rs_exe_hit, rs_mem_hit, mem_is_load);
      fwd_b = fwd_pick(rt_exe_hit, rt_mem_hit, mem_is_load);
      fwd_m = id_is_store & id_rt_used & rt_load_hit & ~(id_rs_used & rs_load_hit);
    end
  end

  // Stage controls, highest priority first
  logic [4:0] en_vec, rst_vec;  // {if, id, exe, mem, wb}

  always_comb begin
    en_vec  = 5'b11111;
    rst_vec = 5'b00000;
    if (rst) begin
      rst_vec = 5'b11111;
    end else if (mem_wait || dbg_hold) begin
      en_vec = 5'b00000;
    end else if (bubble) begin
      en_vec[4:3] = 2'b00;
      rst_vec[2]  = 1'b1;
    end else if (id_branch_taken && (DELAY_SLOT == 0)) begin
      rst_vec[3] = 1'b1;
    end
  end

  assign {if_en, id_en, exe_en, mem_en, wb_en}      = en_vec;
  assign {if_rst, id_rst, exe_rst, mem_rst, wb_rst} = rst_vec;

  // MDU occupancy; id_en already excludes every stall and bubble case.
  logic mdu_issue;
  assign mdu_issue = id_is_mdu & id_en & ~rst;

  mdu_occupancy_ctr #(
    .MDU_CYCLES(MDU_CYCLES)
  ) u_mdu_ctr (
    .clk  (clk),
    .rst  (rst),
    .issue(mdu_issue),
    .busy (mdu_busy)
  );

  // Step edge detector and stall statistics
  logic [SCNT_W-1:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!id_en && !rst && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + SCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_prev_q    <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      step_prev_q    <= debug_step;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MDU_CYCLES=4, no delay slot, 4-bit stall counter).
module tb_pipeline_hazard_ctrl;

  localparam int unsigned AW     = 5;
  localparam int unsigned MDU    = 4;
  localparam int unsigned SCNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic debug_en, debug_step;
  logic [AW-1:0] id_rs_addr, id_rt_addr, exe_waddr, mem_waddr;
  logic id_rs_used, id_rt_used, id_is_store, id_is_mdu, id_reads_hilo, id_branch_taken;
  logic exe_wen, exe_is_load, mem_wen, mem_is_load, mem_ready;
  logic [1:0] fwd_a, fwd_b;
  logic fwd_m;
  logic if_en, id_en, exe_en, mem_en, wb_en;
  logic if_rst, id_rst, exe_rst, mem_rst, wb_rst;
  logic mdu_busy;
  logic [SCNT_W-1:0] stall_cycles;

  logic [4:0] en_v, rst_v;
  assign en_v  = {if_en, id_en, exe_en, mem_en, wb_en};
  assign rst_v = {if_rst, id_rst, exe_rst, mem_rst, wb_rst};

  pipeline_hazard_ctrl #(
    .AW        (AW),
    .MDU_CYCLES(MDU),
    .DELAY_SLOT(0),
    .SCNT_W    (SCNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .debug_en       (debug_en),
    .debug_step     (debug_step),
    .id_rs_addr     (id_rs_addr),
    .id_rt_addr     (id_rt_addr),
    .id_rs_used     (id_rs_used),
    .id_rt_used     (id_rt_used),
    .id_is_store    (id_is_store),
    .id_is_mdu      (id_is_mdu),
    .id_reads_hilo  (id_reads_hilo),
    .id_branch_taken(id_branch_taken),
    .exe_wen        (exe_wen),
    .exe_is_load    (exe_is_load),
    .exe_waddr      (exe_waddr),
    .mem_wen        (mem_wen),
    .mem_is_load    (mem_is_load),
    .mem_waddr      (mem_waddr),
    .mem_ready      (mem_ready),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .fwd_m          (fwd_m),
    .if_en          (if_en),
    .id_en          (id_en),
    .exe_en         (exe_en),
    .mem_en         (mem_en),
    .wb_en          (wb_en),
    .if_rst         (if_rst),
    .id_rst         (id_rst),
    .exe_rst        (exe_rst),
    .mem_rst        (mem_rst),
    .wb_rst         (wb_rst),
    .mdu_busy       (mdu_busy),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    debug_en = 1'b0;  debug_step = 1'b0;
    id_rs_addr = '0;  id_rt_addr = '0;  exe_waddr = '0;  mem_waddr = '0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; id_is_store = 1'b0; id_is_mdu = 1'b0;
    id_reads_hilo = 1'b0; id_branch_taken = 1'b0;
    exe_wen = 1'b0; exe_is_load = 1'b0; mem_wen = 1'b0; mem_is_load = 1'b0;
    mem_ready = 1'b1;
  endtask

  task automatic exe_load(input logic [AW-1:0] r);
    exe_wen = 1'b1; exe_is_load = 1'b1; exe_waddr = r;
  endtask

  int unsigned adv_cnt;
  logic [5:0] step_pat;
  logic [5:0] adv_pat;

  initial begin
    // Reset: forwarding forced off even with a matching producer in EXE
    idle();
    rst = 1'b1;
    exe_wen = 1'b1; exe_waddr = 5'd2; id_rs_addr = 5'd2; id_rs_used = 1'b1;
    #3;
    check_eq("rst_fwd_a", 32'(fwd_a), 32'(2'b00));
    check_eq("rst_fwd_m", 32'(fwd_m), 32'(1'b0));
    check_eq("rst_en", 32'(en_v), 32'(5'b11111));
    check_eq("rst_rst", 32'(rst_v), 32'(5'b11111));
    check_eq("rst_busy", 32'(mdu_busy), 32'(1'b0));
    check_eq("rst_scnt", 32'(stall_cycles), 32'(0));
    tick();
    rst = 1'b0;
    idle();
    #1;
    check_eq("idle_en", 32'(en_v), 32'(5'b11111));
    check_eq("idle_rst", 32'(rst_v), 32'(5'b00000));

    // lw r2 in EXE, add r3,r2,r4 in ID: one bubble, then load-data forward
    exe_load(5'd2);
    id_rs_addr = 5'd2; id_rs_used = 1'b1; id_rt_addr = 5'd4; id_rt_used = 1'b1;
    #1;
    check_eq("lu_en", 32'(en_v), 32'(5'b00111));
    check_eq("lu_rst", 32'(rst_v), 32'(5'b00100));
    tick();
    exe_wen = 1'b0; exe_is_load = 1'b0; exe_waddr = '0;
    mem_wen = 1'b1; mem_is_load = 1'b1; mem_waddr = 5'd2;
    #1;
    check_eq("lu_fwd_a", 32'(fwd_a), 32'(2'b11));
    check_eq("lu_en2", 32'(en_v), 32'(5'b11111));
    check_eq("lu_scnt", 32'(stall_cycles), 32'(1));

    // lw r2 in EXE, sw r2,0(r5) in ID: no stall, store data via fwd_m
    idle();
    exe_load(5'd2);
    id_is_store = 1'b1; id_rs_addr = 5'd5; id_rs_used = 1'b1;
    id_rt_addr = 5'd2; id_rt_used = 1'b1;
    #1;
    check_eq("st_fwd_m", 32'(fwd_m), 32'(1'b1));
    check_eq("st_fwd_b", 32'(fwd_b), 32'(2'b01));
    check_eq("st_fwd_a", 32'(fwd_a), 32'(2'b00));
    check_eq("st_en", 32'(en_v), 32'(5'b11111));
    // Base register also from the load: interlock, no fwd_m
    id_rs_addr = 5'd2;
    #1;
    check_eq("st_rs_fwd_m", 32'(fwd_m), 32'(1'b0));
    check_eq("st_rs_en", 32'(en_v), 32'(5'b00111));

    // ALU producers in EXE and MEM: EXE wins; MEM only; r0 never forwarded
    idle();
    exe_wen = 1'b1; exe_waddr = 5'd2; mem_wen = 1'b1; mem_waddr = 5'd2;
    id_rs_addr = 5'd2; id_rs_used = 1'b1; id_rt_addr = 5'd2; id_rt_used = 1'b1;
    #1;
    check_eq("alu_exe_a", 32'(fwd_a), 32'(2'b01));
    check_eq("alu_exe_en", 32'(en_v), 32'(5'b11111));
    exe_waddr = 5'd3;
    #1;
    check_eq("alu_mem_b", 32'(fwd_b), 32'(2'b10));
    exe_waddr = '0; mem_waddr = '0; id_rs_addr = '0;
    #1;
    check_eq("alu_r0_a", 32'(fwd_a), 32'(2'b00));

    // mult issue, mfhi waits MDU cycles; a taken branch in ID never flushes while stalled
    idle();
    id_is_mdu = 1'b1;
    #1;
    check_eq("mdu_iss_en", 32'(en_v), 32'(5'b11111));
    check_eq("mdu_iss_busy", 32'(mdu_busy), 32'(1'b0));
    tick();
    id_is_mdu = 1'b0; id_reads_hilo = 1'b1; id_branch_taken = 1'b1;
    for (int i = 0; i < int'(MDU); i++) begin
      #1;
      check_eq($sformatf("mdu_busy_%0d", i), 32'(mdu_busy), 32'(1'b1));
      check_eq($sformatf("mdu_hold_%0d", i), 32'(en_v), 32'(5'b00111));
      check_eq($sformatf("mdu_rst_%0d", i), 32'(rst_v), 32'(5'b00100));
      tick();
    end
    #1;
    check_eq("mdu_done_busy", 32'(mdu_busy), 32'(1'b0));
    check_eq("mdu_done_en", 32'(en_v), 32'(5'b11111));
    check_eq("br_flush", 32'(rst_v), 32'(5'b01000));
    check_eq("mdu_scnt", 32'(stall_cycles), 32'(5));
    tick();

    // Memory wait for 3 cycles with a pending load-use; it resurfaces on release
    idle();
    mem_wen = 1'b1; mem_is_load = 1'b1; mem_waddr = 5'd6; mem_ready = 1'b0;
    exe_load(5'd7);
    id_rs_addr = 5'd7; id_rs_used = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("mw_en_%0d", i), 32'(en_v), 32'(5'b00000));
      check_eq($sformatf("mw_rst_%0d", i), 32'(rst_v), 32'(5'b00000));
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check_eq("mw_rel_en", 32'(en_v), 32'(5'b00111));
    check_eq("mw_rel_rst", 32'(rst_v), 32'(5'b00100));
    tick();
    #1;
    check_eq("mw_scnt", 32'(stall_cycles), 32'(9));

    // Reset during the second wait cycle with the MDU busy
    idle();
    id_is_mdu = 1'b1;
    tick();
    id_is_mdu = 1'b0;
    mem_wen = 1'b1; mem_is_load = 1'b1; mem_waddr = 5'd6; mem_ready = 1'b0;
    id_rt_addr = 5'd6; id_rt_used = 1'b1;
    #1;
    check_eq("rw_busy", 32'(mdu_busy), 32'(1'b1));
    check_eq("rw_en1", 32'(en_v), 32'(5'b00000));
    tick();
    #1;
    check_eq("rw_en2", 32'(en_v), 32'(5'b00000));
    check_eq("rw_fwd_b", 32'(fwd_b), 32'(2'b11));
    check_eq("rw_scnt", 32'(stall_cycles), 32'(10));
    rst = 1'b1;
    #1;
    check_eq("rw_rst_vec", 32'(rst_v), 32'(5'b11111));
    check_eq("rw_rst_en", 32'(en_v), 32'(5'b11111));
    check_eq("rw_rst_busy", 32'(mdu_busy), 32'(1'b0));
    check_eq("rw_rst_scnt", 32'(stall_cycles), 32'(0));
    check_eq("rw_rst_fwd_b", 32'(fwd_b), 32'(2'b00));
    tick();
    rst = 1'b0;
    idle();

    // Debug single-step: pattern 0,1,1,0,1,0 gives advances on cycles 1 and 4
    debug_en = 1'b1;
    step_pat = 6'b010110;
    adv_pat  = 6'b010010;
    adv_cnt  = 0;
    for (int i = 0; i < 6; i++) begin
      debug_step = step_pat[i];
      #1;
      check_eq($sformatf("dbg_id_en_%0d", i), 32'(id_en), 32'(adv_pat[i]));
      if (id_en) adv_cnt++;
      tick();
    end
    check_eq("dbg_adv_cnt", 32'(adv_cnt), 32'(2));
    check_eq("dbg_scnt", 32'(stall_cycles), 32'(4));

    // Stall counter saturates at all-ones
    debug_step = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_eq("sat_id_en", 32'(id_en), 32'(1'b0));
    check_eq("sat_scnt", 32'(stall_cycles), 32'(15));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
